// File: rtl/dpram_pkg.sv
// Shared types and constants for the parametrised dual-port RAM.
package dpram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } dpram_st_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/dpram_rdpipe.sv
// Per-port read output stage: captures read data/valid, optionally adding a second register.
module dpram_rdpipe #(
  parameter int DW      = 8,
  parameter int OUT_REG = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [DW-1:0] rd_data,
  output logic          vld,
  output logic [DW-1:0] data_out
);

  logic          vld_p0;
  logic [DW-1:0] data_p0;

  // Stage p0: capture at the access edge; data holds when no read occurs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= rd_en;
      if (rd_en) data_p0 <= rd_data;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic          vld_p1;
      logic [DW-1:0] data_p1;

      // Stage p1: optional output register, keeps draining while the array is busy
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= data_p0;
        end
      end

      assign vld      = vld_p1;
      assign data_out = data_p1;
    end else begin : g_no_reg
      assign vld      = vld_p0;
      assign data_out = data_p0;
    end
  endgenerate

endmodule

// File: rtl/dpram_param.sv
// True dual-port RAM with selectable read-during-write, port-0-wins write
// arbitration and a clear engine that sweeps the array after reset or on request.
module dpram_param
  import dpram_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 6,
  parameter int RDW_MODE = RDW_READ_FIRST,
  parameter int OUT_REG  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en0,
  input  logic          wr0,
  input  logic [AW-1:0] add0,
  input  logic [DW-1:0] data0_in,
  output logic [DW-1:0] data0_out,
  output logic          vld0,
  input  logic          en1,
  input  logic          wr1,
  input  logic [AW-1:0] add1,
  input  logic [DW-1:0] data1_in,
  output logic [DW-1:0] data1_out,
  output logic          vld1,
  input  logic          clr,
  output logic          busy,
  output logic          wcoll
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST  = {AW{1'b1}};

  logic [DW-1:0] mem [DEPTH];

  dpram_st_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  logic          acc0, acc1, we0, we1, coll;
  logic [DW-1:0] rd_data0, rd_data1;

  assign busy = (state_q == CLEAR);
  assign acc0 = en0 & ~busy;
  assign acc1 = en1 & ~busy;
  assign we0  = acc0 & wr0;
  assign we1  = acc1 & wr1;
  assign coll = we0 & we1 & (add0 == add1);

  // Array contents before the edge give read-first on both ports for free
  always_comb begin
    rd_data0 = mem[add0];
    rd_data1 = mem[add1];
    if ((RDW_MODE == RDW_WRITE_FIRST) && wr0) rd_data0 = data0_in;
    if ((RDW_MODE == RDW_WRITE_FIRST) && wr1) rd_data1 = data1_in;
  end

  // Array write: clear sweep has priority, port 0 wins a same-address collision
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ptr_q] <= '0;
    end else begin
      if (we1 && !coll) mem[add1] <= data1_in;
      if (we0)          mem[add0] <= data0_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      wcoll   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wcoll   <= coll;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == LAST) state_d = IDLE;
      end
    endcase
  end

  dpram_rdpipe #(.DW(DW), .OUT_REG(OUT_REG)) u_rdpipe0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (acc0),
    .rd_data  (rd_data0),
    .vld      (vld0),
    .data_out (data0_out)
  );

  dpram_rdpipe #(.DW(DW), .OUT_REG(OUT_REG)) u_rdpipe1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (acc1),
    .rd_data  (rd_data1),
    .vld      (vld1),
    .data_out (data1_out)
  );

endmodule

// File: tb/tb_dpram_param.sv
// Bench for dpram_param: two 8x64 instances (default, and write-first with output
// register) checked against a behavioural model every cycle, plus a 32x16 instance.
module tb_dpram_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for instances A and B
  logic       en0, wr0, en1, wr1, clr;
  logic [5:0] add0, add1;
  logic [7:0] d0, d1;

  logic [7:0] a_data0, a_data1, b_data0, b_data1;
  logic       a_vld0, a_vld1, a_busy, a_wcoll;
  logic       b_vld0, b_vld1, b_busy, b_wcoll;

  // instance C (wide)
  logic        c_en0, c_wr0, c_en1, c_wr1, c_clr;
  logic [3:0]  c_add0, c_add1;
  logic [31:0] c_d0, c_d1, c_data0, c_data1;
  logic        c_vld0, c_vld1, c_busy, c_wcoll;

  int n_chk = 0;
  int n_fail = 0;

  dpram_param #(.DW(8), .AW(6), .RDW_MODE(0), .OUT_REG(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .en0(en0), .wr0(wr0), .add0(add0), .data0_in(d0), .data0_out(a_data0), .vld0(a_vld0),
    .en1(en1), .wr1(wr1), .add1(add1), .data1_in(d1), .data1_out(a_data1), .vld1(a_vld1),
    .clr(clr), .busy(a_busy), .wcoll(a_wcoll));

  dpram_param #(.DW(8), .AW(6), .RDW_MODE(1), .OUT_REG(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .en0(en0), .wr0(wr0), .add0(add0), .data0_in(d0), .data0_out(b_data0), .vld0(b_vld0),
    .en1(en1), .wr1(wr1), .add1(add1), .data1_in(d1), .data1_out(b_data1), .vld1(b_vld1),
    .clr(clr), .busy(b_busy), .wcoll(b_wcoll));

  dpram_param #(.DW(32), .AW(4), .RDW_MODE(0), .OUT_REG(0)) u_c (
    .clk(clk), .rst_n(rst_n),
    .en0(c_en0), .wr0(c_wr0), .add0(c_add0), .data0_in(c_d0), .data0_out(c_data0), .vld0(c_vld0),
    .en1(c_en1), .wr1(c_wr1), .add1(c_add1), .data1_in(c_d1), .data1_out(c_data1), .vld1(c_vld1),
    .clr(c_clr), .busy(c_busy), .wcoll(c_wcoll));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: array contents, remaining busy cycles, expected outputs.
  logic [7:0] m_mem [64];
  int         m_busy = 64;
  logic       ea_vld [2] = '{1'b0, 1'b0};
  logic [7:0] ea_dat [2] = '{8'h00, 8'h00};
  logic       eb_vld [2] = '{1'b0, 1'b0};
  logic [7:0] eb_dat [2] = '{8'h00, 8'h00};
  logic       pend_vld [2] = '{1'b0, 1'b0};
  logic [7:0] pend_dat [2] = '{8'h00, 8'h00};
  logic       e_wcoll = 1'b0;
  logic       e_busy = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 64;
      for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
      for (int p = 0; p < 2; p++) begin
        ea_vld[p] = 1'b0; ea_dat[p] = 8'h00;
        eb_vld[p] = 1'b0; eb_dat[p] = 8'h00;
        pend_vld[p] = 1'b0; pend_dat[p] = 8'h00;
      end
      e_wcoll = 1'b0;
      e_busy  = 1'b1;
    end else begin
      logic       acc0, acc1;
      logic [7:0] old0, old1;
      acc0 = en0 && (m_busy == 0);
      acc1 = en1 && (m_busy == 0);
      old0 = m_mem[add0];
      old1 = m_mem[add1];
      for (int p = 0; p < 2; p++) begin
        eb_vld[p] = pend_vld[p];
        if (pend_vld[p]) eb_dat[p] = pend_dat[p];
      end
      ea_vld[0] = acc0;
      ea_vld[1] = acc1;
      if (acc0) ea_dat[0] = old0;
      if (acc1) ea_dat[1] = old1;
      pend_vld[0] = acc0;
      pend_vld[1] = acc1;
      if (acc0) pend_dat[0] = wr0 ? d0 : old0;
      if (acc1) pend_dat[1] = wr1 ? d1 : old1;
      e_wcoll = acc0 && acc1 && wr0 && wr1 && (add0 == add1);
      if (acc1 && wr1) m_mem[add1] = d1;
      if (acc0 && wr0) m_mem[add0] = d0;
      if (m_busy > 0) begin
        m_busy--;
      end else if (clr) begin
        m_busy = 64;
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
      end
      e_busy = (m_busy > 0);
    end
  end

  always @(negedge clk) begin
    chk("a_data0", 32'(a_data0), 32'(ea_dat[0]));
    chk("a_data1", 32'(a_data1), 32'(ea_dat[1]));
    chk("a_vld0",  32'(a_vld0),  32'(ea_vld[0]));
    chk("a_vld1",  32'(a_vld1),  32'(ea_vld[1]));
    chk("a_wcoll", 32'(a_wcoll), 32'(e_wcoll));
    chk("a_busy",  32'(a_busy),  32'(e_busy));
    chk("b_data0", 32'(b_data0), 32'(eb_dat[0]));
    chk("b_data1", 32'(b_data1), 32'(eb_dat[1]));
    chk("b_vld0",  32'(b_vld0),  32'(eb_vld[0]));
    chk("b_vld1",  32'(b_vld1),  32'(eb_vld[1]));
    chk("b_wcoll", 32'(b_wcoll), 32'(e_wcoll));
    chk("b_busy",  32'(b_busy),  32'(e_busy));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en0 = 1'b0; wr0 = 1'b0; en1 = 1'b0; wr1 = 1'b0; clr = 1'b0;
  endtask

  task automatic rd1(input logic [5:0] a);
    en1 = 1'b1; wr1 = 1'b0; add1 = a;
  endtask

  task automatic wr_p0(input logic [5:0] a, input logic [7:0] d);
    en0 = 1'b1; wr0 = 1'b1; add0 = a; d0 = d;
  endtask

  logic [7:0] wv [4];

  initial begin
    wv = '{8'h24, 8'h81, 8'h09, 8'h63};
    idle();
    add0 = '0; add1 = '0; d0 = '0; d1 = '0;
    c_en0 = 1'b0; c_wr0 = 1'b0; c_en1 = 1'b0; c_wr1 = 1'b0; c_clr = 1'b0;
    c_add0 = '0; c_add1 = '0; c_d0 = '0; c_d1 = '0;

    repeat (3) step();
    chk("rst_a_data0", 32'(a_data0), 32'h0);
    chk("rst_a_vld1",  32'(a_vld1),  32'h0);
    chk("rst_a_wcoll", 32'(a_wcoll), 32'h0);
    chk("rst_a_busy",  32'(a_busy),  32'h1);
    chk("rst_b_data1", 32'(b_data1), 32'h0);
    chk("rst_c_busy",  32'(c_busy),  32'h1);

    // clear after reset, with ignored accesses while busy
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i < 60) begin
        wr_p0(6'd9, 8'hFF);
        rd1(6'(i));
      end else begin
        idle();
      end
      step();
      if (i == 14) chk("c_busy_15", 32'(c_busy), 32'h1);
      if (i == 15) chk("c_busy_16", 32'(c_busy), 32'h0);
      if (i == 62) chk("a_busy_63", 32'(a_busy), 32'h1);
    end
    chk("a_busy_64", 32'(a_busy), 32'h0);

    for (int i = 0; i < 64; i++) begin
      rd1(6'(i));
      step();
      if (i == 9) begin
        chk("clr_rd9_data", 32'(a_data1), 32'h0);
        chk("clr_rd9_vld",  32'(a_vld1),  32'h1);
      end
    end
    idle();

    // cross-port write then read
    for (int i = 0; i < 4; i++) begin
      wr_p0(6'(i), wv[i]);
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      rd1(6'(i));
      step();
      chk("xrd_a", 32'(a_data1), 32'(wv[i]));
      if (i > 0) chk("xrd_b", 32'(b_data1), 32'(wv[i-1]));
    end
    idle();
    step();
    chk("xrd_b_last", 32'(b_data1), 32'h63);
    chk("xrd_b_vld",  32'(b_vld1),  32'h1);
    chk("xrd_a_novld", 32'(a_vld1), 32'h0);

    // write collision
    wr_p0(6'd5, 8'hAA);
    en1 = 1'b1; wr1 = 1'b1; add1 = 6'd5; d1 = 8'h55;
    step();
    idle();
    chk("wcoll_pulse_a", 32'(a_wcoll), 32'h1);
    chk("wcoll_pulse_b", 32'(b_wcoll), 32'h1);
    step();
    chk("wcoll_drop", 32'(a_wcoll), 32'h0);
    rd1(6'd5);
    step();
    idle();
    chk("coll_rd", 32'(a_data1), 32'hAA);

    // read-during-write
    wr_p0(6'd7, 8'h11);
    step();
    wr_p0(6'd7, 8'h22);
    rd1(6'd7);
    step();
    idle();
    chk("rdw_a_d0", 32'(a_data0), 32'h11);
    chk("rdw_a_d1", 32'(a_data1), 32'h11);
    step();
    chk("rdw_b_d0", 32'(b_data0), 32'h22);
    chk("rdw_b_d1", 32'(b_data1), 32'h11);

    // both ports read one address
    en0 = 1'b1; wr0 = 1'b0; add0 = 6'd3;
    rd1(6'd3);
    step();
    idle();
    chk("dual_rd0", 32'(a_data0), 32'h63);
    chk("dual_rd1", 32'(a_data1), 32'h63);
    step();

    // fill, then clr with a read in flight, then reset at sweep pointer 20
    for (int i = 0; i < 64; i++) begin
      wr_p0(6'(i), 8'(i * 3 + 1));
      rd1(6'(63 - i));
      step();
    end
    idle();
    rd1(6'd2);
    clr = 1'b1;
    step();
    idle();
    chk("clr_busy", 32'(a_busy), 32'h1);
    chk("clr_inflight_a", 32'(a_data1), 32'h07);
    step();
    chk("clr_inflight_b", 32'(b_data1), 32'h07);
    chk("clr_inflight_bv", 32'(b_vld1), 32'h1);
    for (int i = 0; i < 19; i++) begin
      wr_p0(6'd30, 8'hEE);
      rd1(6'd30);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_data1", 32'(a_data1), 32'h0);
    chk("mid_rst_b_data0", 32'(b_data0), 32'h0);
    chk("mid_rst_busy",    32'(a_busy),  32'h1);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i >= 60) idle();
      step();
    end
    idle();
    chk("mid_rst_done", 32'(a_busy), 32'h0);
    for (int i = 0; i < 64; i++) begin
      rd1(6'(i));
      step();
      if (i == 30) chk("post_clr_rd30", 32'(a_data1), 32'h0);
    end
    idle();
    step();

    // wide instance round trip
    c_en0 = 1'b1; c_wr0 = 1'b1; c_add0 = 4'd15; c_d0 = 32'hDEADBEEF;
    step();
    c_en0 = 1'b0; c_wr0 = 1'b0;
    chk("c_wr_old_data", c_data0, 32'h0);
    chk("c_wr_vld0", 32'(c_vld0), 32'h1);
    c_en1 = 1'b1; c_wr1 = 1'b0; c_add1 = 4'd15;
    step();
    chk("c_rd15", c_data1, 32'hDEADBEEF);
    chk("c_rd15_vld", 32'(c_vld1), 32'h1);
    c_add1 = 4'd0;
    step();
    c_en1 = 1'b0;
    chk("c_rd0", c_data1, 32'h0);
    chk("c_wcoll", 32'(c_wcoll), 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_param.md
# dpram_param

Parametrised true dual-port RAM, the successor to the fixed 8-bit × 64 `dpram` used by the ASIC flow. Two symmetric read/write ports share one array on a single clock. It adds the following:
- configurable width and depth;
- selectable read-during-write behaviour;
- optional output pipeline register;
- per-port read-valid strobes;
- deterministic write-collision arbitration;
- a hardware clear engine that zeroes the array after reset or on request.

It sits wherever the design needs shared buffer storage between two agents.

## Interface
- `DW`, 8, data width in bits (≥1)
- `AW`, 6, address width; depth = 2**AW
- `RDW_MODE`, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
- `OUT_REG`, 0, 0 = 1-cycle read latency, 1 = 2-cycle latency with extra output register

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en0` / `en1`  in  1  port enable; no access when low
- `wr0` / `wr1`  in  1  1 = write, 0 = read (qualified by en)
- `add0` / `add1`  in  AW  port address
- `data0_in` / `data1_in`  in  DW  write data
- `data0_out` / `data1_out`  out  DW  read data
- `vld0` / `vld1`  out  1  read data valid, aligned with dataN_out
- `clr`  in  1  single-cycle request to zero the whole array
- `busy`  out  1  clear engine active; port accesses ignored
- `wcoll`  out  1  one-cycle pulse: both ports wrote the same address

## Operation
- **Access:** a port accesses the array in a cycle when `enN`=1 and `busy`=0. The access is a write if `wrN`=1, otherwise a read.
- **Read:** data is captured at the clock edge. `dataN_out` holds its last value when no read occurs.
- **Same-port read-during-write:** a port performing a write also returns data on `dataN_out` with `vldN`=1. This is old contents if `RDW_MODE`=0, and `data_in` if `RDW_MODE`=1.
- **Cross-port read/write to the same address:** the reader always gets the old contents (read-first), regardless of `RDW_MODE`.
- **Write collision:** both ports write the same address in one cycle.
  - Port 0 wins; port 1 data is discarded.
  - `wcoll`=1 in the following cycle.
  - Reads on both ports to the same address are legal and both return identical data.
- **Clear FSM**, states `IDLE` and `CLEAR`:
  - Reset asserted → `CLEAR` with sweep pointer = 0.
  - `IDLE` + `clr`=1 → `CLEAR`, pointer = 0.
  - In `CLEAR`: write 0 to `mem[pointer]`, increment the pointer. At pointer = 2**AW−1, write that last word and go to `IDLE`.
  - `clr` asserted during `CLEAR` is ignored; the sweep is not restarted.
  - `busy`=1 exactly while the state is `CLEAR`.
- **Reset mid-clear or mid-access:** restarts the sweep from 0. In-flight reads are dropped: `vldN` is 0 and outputs are 0.
- **Addresses:** always in range, since depth is exactly 2**AW. There is no wrap logic beyond the sweep pointer.

## Timing
- **Reset values:**
  - `dataN_out` = 0, `vldN` = 0, `wcoll` = 0.
  - `busy` = 1, and stays 1 for 2**AW cycles after `rst_n` is released.
- **Read latency:**
  - `OUT_REG`=0: data and `vldN` appear one cycle after the access edge.
  - `OUT_REG`=1: two cycles after the access edge.
  - `vldN` is high for exactly one cycle per read and is fully pipelined (back-to-back reads give continuous `vld`).
- **Write:** written data is visible to a read issued on the next cycle, on either port.
- **Clear:** `clr` sampled in cycle t sets `busy`=1 from t+1 for 2**AW cycles. The first access accepted is in the cycle `busy` returns to 0.
- **Accesses during `busy`:**
  - No write occurs.
  - `vldN` stays 0.
  - Reads already in the `OUT_REG` pipeline still complete.

## Structure
- **Package `dpram_pkg`:**
  - state enum `dpram_st_e {IDLE, CLEAR}`
  - constants `RDW_READ_FIRST`=0 and `RDW_WRITE_FIRST`=1
- **Sub-module `dpram_rdpipe`:** instantiated once per port. It holds the data/valid output stage, with `OUT_REG` selecting 1 or 2 register stages, and resets outputs to 0.
- **Top level:** contains the array, collision arbitration, and the clear FSM with its AW-bit sweep pointer.

## Test plan
- **Clear after reset:** after reset with default params, `busy` is high for 64 cycles, then port 1 reads addresses 0..63 → all 0x00 with `vld1` one cycle later.
- **Cross-port write/read:** port 0 writes 0x24, 0x81, 0x09, 0x63 to addresses 0..3, then port 1 reads 0..3 → same values in order, 1-cycle latency. With `OUT_REG`=1 → 2-cycle latency.
- **Write collision:** both ports write address 5 in the same cycle (0xAA on port 0, 0x55 on port 1) → `wcoll` pulses one cycle, and a later read of address 5 returns 0xAA.
- **Read-during-write:** address 7 holds 0x11; port 0 writes 0x22 to address 7 while port 1 reads address 7.
  - `RDW_MODE`=0: `data0_out`=0x11, `data1_out`=0x11.
  - `RDW_MODE`=1: `data0_out`=0x22, `data1_out`=0x11.
- **`clr` with reset mid-sweep:** pulse `clr` with memory filled, then assert `rst_n` low at sweep pointer 20 → sweep restarts from 0, and all 64 words read 0x00 afterwards. Accesses during `busy` produce no `vld` and no write.
- **Wide configuration:** `DW`=32, `AW`=4 → 16-cycle clear, and a write/read of 0xDEADBEEF at address 15 round-trips.
